// File: rtl/lcd_reg_display_if.sv
// Handshake bundle between the register-display sequencer and the
// character-LCD driver.
//   lcd_start     : level request, held high for the whole transaction
//   lcd_data      : DDRAM address (address phase) or ASCII character
//   lcd_loc_req   : 1 = transaction begins with an address set
//   lcd_done_tick : driver completion flag (only its rising edge matters)
// master = sequencer side, slave = driver side.
interface lcd_reg_display_if;
   logic       lcd_start;
   logic [7:0] lcd_data;
   logic       lcd_loc_req;
   logic       lcd_done_tick;

   modport master (
      output lcd_start,
      output lcd_data,
      output lcd_loc_req,
      input  lcd_done_tick
   );

   modport slave (
      input  lcd_start,
      input  lcd_data,
      input  lcd_loc_req,
      output lcd_done_tick
   );
endinterface

// File: rtl/lcd_reg_display.sv
// lcd_reg_display
// Sequencer in front of the character-LCD driver. Snapshots four 8-bit
// registers and renders each as "L:hh" on a 2x16 display, one character
// per driver transaction. reg0/reg1 go to row 0 (columns 0 and 5),
// reg2/reg3 to row 1. The first character of every field carries a
// DDRAM address; the driver sees the address first and the label
// character after LOC_SWITCH cycles.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   reg0..reg3    : live register values
//   refresh_req   : 1-cycle pulse forcing a full redraw
//   lcd           : driver handshake (master modport)
//   busy          : high from frame start until frame_done
//   frame_done    : 1-cycle pulse after the 16th character completes
//   timeout_err   : sticky, set when any character hit TIMEOUT
module lcd_reg_display #(
   parameter int unsigned HOLD_TIME  = 500,
   parameter int unsigned INIT_WAIT  = 3200,
   parameter int unsigned LOC_SWITCH = 2 * HOLD_TIME + HOLD_TIME / 2,
   parameter int unsigned TIMEOUT    = 8000,
   parameter logic [31:0] LABELS     = "ABOP"
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              reg0,
   input  logic [7:0]              reg1,
   input  logic [7:0]              reg2,
   input  logic [7:0]              reg3,
   input  logic                    refresh_req,
   lcd_reg_display_if.master       lcd,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    timeout_err
);

   // One counter serves INIT, the wait timeout and the address->char swap,
   // so it is sized for the largest of the three and never wraps.
   localparam int unsigned CMAX_A = (INIT_WAIT > TIMEOUT) ? INIT_WAIT : TIMEOUT;
   localparam int unsigned CMAX   = (CMAX_A > LOC_SWITCH) ? CMAX_A : LOC_SWITCH;
   localparam int unsigned CW     = $clog2(CMAX + 1);

   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
   localparam logic [CW-1:0] TO_CNT    = CW'(TIMEOUT);
   localparam logic [CW-1:0] LS_LAST   = CW'(LOC_SWITCH - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    ch_q;
   logic [31:0]   snap_q;
   logic          pending_q;
   logic          done_prev_q;
   logic          start_q;
   logic [7:0]    data_q;
   logic          loc_q;
   logic          busy_q;
   logic          frame_done_q;
   logic          timeout_err_q;

   logic [31:0]   regs_now;
   logic          done_edge;
   logic [7:0]    cur_char;
   logic [7:0]    cur_addr;
   logic          wait_end;

   // ASCII for one hex nibble, uppercase A-F.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) begin
         return 8'h30 + {4'h0, n};
      end
      return 8'h37 + {4'h0, n};
   endfunction

   // Character for position ch of the frame, taken from a register snapshot.
   function automatic logic [7:0] char_at(input logic [3:0] ch, input logic [31:0] snap);
      logic [7:0] val;
      logic [7:0] lab;
      logic [7:0] res;
      case (ch[3:2])
         2'd0:    begin val = snap[31:24]; lab = LABELS[31:24]; end
         2'd1:    begin val = snap[23:16]; lab = LABELS[23:16]; end
         2'd2:    begin val = snap[15:8];  lab = LABELS[15:8];  end
         default: begin val = snap[7:0];   lab = LABELS[7:0];   end
      endcase
      case (ch[1:0])
         2'd0:    res = lab;
         2'd1:    res = 8'h3A;
         2'd2:    res = hex_ascii(val[7:4]);
         default: res = hex_ascii(val[3:0]);
      endcase
      return res;
   endfunction

   // Set-DDRAM command byte for the start of field f.
   function automatic logic [7:0] field_addr(input logic [1:0] f);
      logic [7:0] a;
      a = 8'h80;
      if (f[1]) a = a | 8'h40;
      if (f[0]) a = a | 8'h05;
      return a;
   endfunction

   always_comb begin
      regs_now  = {reg0, reg1, reg2, reg3};
      done_edge = lcd.lcd_done_tick & ~done_prev_q;
      cur_char  = char_at(ch_q, snap_q);
      cur_addr  = field_addr(ch_q[3:2]);
      wait_end  = done_edge | (cnt_q == TO_CNT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_INIT;
         cnt_q         <= '0;
         ch_q          <= '0;
         snap_q        <= '0;
         pending_q     <= 1'b0;
         done_prev_q   <= 1'b0;
         start_q       <= 1'b0;
         data_q        <= '0;
         loc_q         <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         done_prev_q  <= lcd.lcd_done_tick;
         frame_done_q <= 1'b0;

         // The power-up draw is already queued during INIT, so a refresh there is dropped.
         if (refresh_req && (state_q != S_INIT)) begin
            pending_q <= 1'b1;
         end

         unique case (state_q)
            S_INIT: begin
               if (cnt_q == INIT_LAST) begin
                  cnt_q     <= '0;
                  pending_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_IDLE: begin
               if (pending_q || (regs_now != snap_q)) begin
                  snap_q <= regs_now;
                  // A refresh arriving on the launch cycle is kept for one more frame.
                  if (!refresh_req) begin
                     pending_q <= 1'b0;
                  end
                  ch_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               start_q <= 1'b1;
               cnt_q   <= '0;
               if (ch_q[1:0] == 2'd0) begin
                  loc_q  <= 1'b1;
                  data_q <= cur_addr;
               end else begin
                  loc_q  <= 1'b0;
                  data_q <= cur_char;
               end
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               if (wait_end) begin
                  start_q <= 1'b0;
                  loc_q   <= 1'b0;
                  if (!done_edge) begin
                     timeout_err_q <= 1'b1;
                  end
                  if (ch_q == 4'd15) begin
                     frame_done_q <= 1'b1;
                     busy_q       <= 1'b0;
                     state_q      <= S_DONE;
                  end else begin
                     ch_q    <= ch_q + 1'b1;
                     state_q <= S_ISSUE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  // Address byte is replaced by the label once the driver has latched it.
                  if (loc_q && (cnt_q == LS_LAST)) begin
                     data_q <= cur_char;
                  end
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_INIT;
            end
         endcase
      end
   end

   assign lcd.lcd_start   = start_q;
   assign lcd.lcd_data    = data_q;
   assign lcd.lcd_loc_req = loc_q;
   assign busy            = busy_q;
   assign frame_done      = frame_done_q;
   assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_lcd_reg_display.sv
module tb_lcd_reg_display;
   localparam int unsigned HOLD  = 4;
   localparam int unsigned INITW = 40;
   localparam int unsigned TOUT  = 100;
   localparam int unsigned LOCSW = 10;
   localparam int unsigned ACK   = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] r0, r1, r2, r3;
   logic       refresh_req;
   logic       busy, frame_done, timeout_err;

   lcd_reg_display_if lif();

   lcd_reg_display #(
      .HOLD_TIME (HOLD),
      .INIT_WAIT (INITW),
      .TIMEOUT   (TOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .reg0        (r0),
      .reg1        (r1),
      .reg2        (r2),
      .reg3        (r3),
      .refresh_req (refresh_req),
      .lcd         (lif),
      .busy        (busy),
      .frame_done  (frame_done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   string HEX = "0123456789ABCDEF";
   string LAB = "ABOP";

   function automatic logic [7:0] exp_char(input int i, input logic [31:0] regs);
      int f, p;
      int v;
      f = i / 4;
      p = i % 4;
      v = int'((regs >> (8 * (3 - f))) & 32'hFF);
      case (p)
         0:       return LAB[f];
         1:       return 8'h3A;
         2:       return HEX[v / 16];
         default: return HEX[v % 16];
      endcase
   endfunction

   function automatic logic [7:0] exp_addr(input int f);
      return 8'(8'h80 + 8'h40 * (f / 2) + 5 * (f % 2));
   endfunction

   // ---------------- driver model ----------------
   bit stuck  = 1'b0;
   int hi_cnt = 0;
   initial begin
      lif.lcd_done_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (stuck)                                         lif.lcd_done_tick = 1'b1;
         else if (lif.lcd_start && hi_cnt == int'(ACK) - 1) lif.lcd_done_tick = 1'b1;
         else                                               lif.lcd_done_tick = 1'b0;
         hi_cnt = lif.lcd_start ? hi_cnt + 1 : 0;
      end
   end

   // ---------------- transaction monitor ----------------
   typedef struct {
      bit         loc;
      logic [7:0] first;
      logic [7:0] last;
      int         len;
      int         sw_at;
      int         nchg;
   } tx_t;

   tx_t txq[$];
   int  ntx      = 0;
   int  fd_cnt   = 0;
   int  busy_bad = 0;

   initial begin
      tx_t cur;
      bit  prev;
      prev = 1'b0;
      cur  = '{loc: 1'b0, first: 8'h00, last: 8'h00, len: 0, sw_at: -1, nchg: 0};
      forever begin
         @(negedge clk);
         if (lif.lcd_start && !prev) begin
            cur.loc   = lif.lcd_loc_req;
            cur.first = lif.lcd_data;
            cur.last  = lif.lcd_data;
            cur.len   = 1;
            cur.sw_at = -1;
            cur.nchg  = 0;
            ntx++;
         end else if (lif.lcd_start) begin
            if (lif.lcd_data != cur.last) begin
               cur.nchg++;
               cur.sw_at = cur.len;
            end
            if (lif.lcd_loc_req != cur.loc) cur.nchg++;
            cur.last = lif.lcd_data;
            cur.len++;
         end else if (prev) begin
            txq.push_back(cur);
         end
         prev = lif.lcd_start;
         if (frame_done) begin
            fd_cnt++;
            if (busy) busy_bad++;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_refresh();
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
   endtask

   // Counts quiet cycles after reset release until the first lcd_start.
   task automatic init_gap(input bit with_refresh, input string tag);
      int n;
      n = 0;
      while (!lif.lcd_start && n < 300) begin
         @(negedge clk);
         n++;
         if (n == 2) txq.delete();
         refresh_req = (with_refresh && n == 10);
      end
      refresh_req = 1'b0;
      chk(tag, 32'(n >= int'(INITW) && n <= int'(INITW) + 4), 32'd1);
   endtask

   task automatic wait_fd(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (fd_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(fd_cnt >= target), 32'd1);
   endtask

   task automatic check_frame(input string nm, input logic [31:0] regs, input bit tmo);
      tx_t t;
      for (int i = 0; i < 16; i++) begin
         if (txq.size() == 0) begin
            chk($sformatf("%s.missing%0d", nm, i), 32'(txq.size()), 32'd1);
            return;
         end
         t = txq.pop_front();
         chk($sformatf("%s.c%0d.loc", nm, i), 32'(t.loc), 32'((i % 4) == 0));
         if ((i % 4) == 0) begin
            chk($sformatf("%s.c%0d.addr", nm, i), 32'(t.first), 32'(exp_addr(i / 4)));
            chk($sformatf("%s.c%0d.lab", nm, i), 32'(t.last), 32'(exp_char(i, regs)));
            chk($sformatf("%s.c%0d.swat", nm, i), 32'(t.sw_at), LOCSW);
         end else begin
            chk($sformatf("%s.c%0d.chr", nm, i), 32'(t.first), 32'(exp_char(i, regs)));
            chk($sformatf("%s.c%0d.stab", nm, i), 32'(t.nchg), 32'd0);
         end
         if (tmo) chk($sformatf("%s.c%0d.tlen", nm, i), 32'(t.len >= int'(TOUT) && t.len <= int'(TOUT) + 1), 32'd1);
         else     chk($sformatf("%s.c%0d.len", nm, i), 32'(t.len), ACK);
      end
   endtask

   task automatic check_zero(input string nm);
      chk({nm, ".start"}, 32'(lif.lcd_start), 32'd0);
      chk({nm, ".data"},  32'(lif.lcd_data), 32'd0);
      chk({nm, ".loc"},   32'(lif.lcd_loc_req), 32'd0);
      chk({nm, ".busy"},  32'(busy), 32'd0);
      chk({nm, ".fd"},    32'(frame_done), 32'd0);
      chk({nm, ".terr"},  32'(timeout_err), 32'd0);
   endtask

   function automatic logic [31:0] regs_cat();
      return {r0, r1, r2, r3};
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] s1, s2, old;
      int base, tgt, n;

      rst_n = 1'b0; refresh_req = 1'b0;
      r0 = 8'h00; r1 = 8'h00; r2 = 8'h00; r3 = 8'h00;
      repeat (3) @(negedge clk);
      check_zero("reset");

      // power-up draw; refresh inside INIT must not add a frame
      rst_n = 1'b1;
      init_gap(1'b1, "init_gap");
      wait_fd(1, 3000, "frame0_wait");
      check_frame("f0", regs_cat(), 1'b0);
      idle(60);
      chk("init_refresh_dropped", 32'(fd_cnt), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("no_terr", 32'(timeout_err), 32'd0);

      // register change while idle, including 0xF lo nibble
      r0 = 8'h3F; r3 = 8'hA7;
      wait_fd(2, 3000, "frame1_wait");
      check_frame("f1", regs_cat(), 1'b0);
      idle(60);
      chk("one_frame_per_change", 32'(fd_cnt), 32'd2);

      // random register sets
      for (int k = 0; k < 3; k++) begin
         old = regs_cat();
         r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
         if (regs_cat() == old) r0 = ~r0;
         base = fd_cnt;
         wait_fd(base + 1, 3000, $sformatf("rnd%0d_wait", k));
         check_frame($sformatf("rnd%0d", k), regs_cat(), 1'b0);
         idle(40);
         chk($sformatf("rnd%0d_count", k), 32'(fd_cnt), 32'(base + 1));
      end

      // refresh pulses + reg1 change mid-frame -> exactly one extra frame
      r2 = r2 ^ 8'h5A;
      s1 = regs_cat();
      base = fd_cnt;
      tgt = ntx + 5;
      n = 0;
      while (ntx < tgt && n < 2000) begin @(negedge clk); n++; end
      chk("mid_reach", 32'(ntx >= tgt), 32'd1);
      chk("mid_busy", 32'(busy), 32'd1);
      pulse_refresh();
      idle(7);
      pulse_refresh();
      r1 = r1 + 8'h11;
      s2 = regs_cat();
      wait_fd(base + 2, 6000, "mid_wait");
      check_frame("mid_old", s1, 1'b0);
      check_frame("mid_new", s2, 1'b0);
      idle(80);
      chk("mid_extra_once", 32'(fd_cnt), 32'(base + 2));

      // done_tick stuck high -> every char times out, frame still completes
      stuck = 1'b1;
      idle(3);
      base = fd_cnt;
      pulse_refresh();
      wait_fd(base + 1, 16 * 110 + 300, "tmo_wait");
      check_frame("tmo", regs_cat(), 1'b0 == 1'b1 ? 1'b0 : 1'b1);
      chk("tmo_err_set", 32'(timeout_err), 32'd1);
      stuck = 1'b0;
      idle(3);
      r3 = r3 ^ 8'hFF;
      base = fd_cnt;
      wait_fd(base + 1, 3000, "post_tmo_wait");
      check_frame("post_tmo", regs_cat(), 1'b0);
      chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

      // reset in the middle of a frame at ch=7
      r0 = r0 ^ 8'h81;
      tgt = ntx + 8;
      n = 0;
      while (ntx < tgt && n < 2000) begin @(negedge clk); n++; end
      chk("rst_reach", 32'(ntx >= tgt), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      rst_n = 1'b1;
      base = fd_cnt;
      init_gap(1'b0, "rst_init_gap");
      wait_fd(base + 1, 3000, "rst_redraw_wait");
      check_frame("rst_redraw", regs_cat(), 1'b0);
      idle(40);
      chk("rst_redraw_once", 32'(fd_cnt), 32'(base + 1));
      chk("txq_empty", 32'(txq.size()), 32'd0);
      chk("busy_low_on_fd", 32'(busy_bad), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached (checks=%0d fails=%0d)", checks, fails);
      $fatal(1, "watchdog");
   end

endmodule
